// File: rtl/mem_axi_master_pkg.sv
// Shared AXI definitions for the memory AXI master.
//   - `AXI_*_BITS width macros used for every AXI/client port
//   - FSM state enum and fixed burst/size/response encodings
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_ID_BITS    4
`define AXI_ADDR_BITS  32
`define AXI_LEN_BITS   4
`define AXI_SIZE_BITS  3
`define AXI_BURST_BITS 2
`define AXI_RESP_BITS  2
`define AXI_DATA_BITS  32
`define AXI_STRB_BITS  4
`endif

package mem_axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } axi_state_e;

    localparam logic [`AXI_BURST_BITS-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [`AXI_SIZE_BITS-1:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [`AXI_RESP_BITS-1:0]  AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/mem_axi_master.sv
// Single-outstanding AXI burst master.
// Client side: req_* accepts one read or write burst at a time; wd_* streams
// write data in, rd_* streams read data out; done pulses one cycle after the
// burst completes, with err set if any response was non-OKAY.
// AXI side: full AR/R/AW/W/B master channels. ID/size/burst are fixed.
import mem_axi_master_pkg::*;

module mem_axi_master #(
    parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = '0
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    // client request
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [`AXI_ADDR_BITS-1:0]   req_addr,
    input  logic [`AXI_LEN_BITS-1:0]    req_len,
    // client write data
    input  logic                        wd_valid,
    output logic                        wd_ready,
    input  logic [`AXI_DATA_BITS-1:0]   wd_data,
    input  logic [`AXI_STRB_BITS-1:0]   wd_strb,
    // client read data
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [`AXI_DATA_BITS-1:0]   rd_data,
    output logic                        rd_last,
    // completion
    output logic                        done,
    output logic                        err,
    // AXI AR
    output logic [`AXI_ID_BITS-1:0]     ARID,
    output logic [`AXI_ADDR_BITS-1:0]   ARADDR,
    output logic [`AXI_LEN_BITS-1:0]    ARLEN,
    output logic [`AXI_SIZE_BITS-1:0]   ARSIZE,
    output logic [`AXI_BURST_BITS-1:0]  ARBURST,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    // AXI R
    input  logic [`AXI_ID_BITS-1:0]     RID,
    input  logic [`AXI_DATA_BITS-1:0]   RDATA,
    input  logic [`AXI_RESP_BITS-1:0]   RRESP,
    input  logic                        RLAST,
    input  logic                        RVALID,
    output logic                        RREADY,
    // AXI AW
    output logic [`AXI_ID_BITS-1:0]     AWID,
    output logic [`AXI_ADDR_BITS-1:0]   AWADDR,
    output logic [`AXI_LEN_BITS-1:0]    AWLEN,
    output logic [`AXI_SIZE_BITS-1:0]   AWSIZE,
    output logic [`AXI_BURST_BITS-1:0]  AWBURST,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    // AXI W
    output logic [`AXI_DATA_BITS-1:0]   WDATA,
    output logic [`AXI_STRB_BITS-1:0]   WSTRB,
    output logic                        WLAST,
    output logic                        WVALID,
    input  logic                        WREADY,
    // AXI B
    input  logic [`AXI_ID_BITS-1:0]     BID,
    input  logic [`AXI_RESP_BITS-1:0]   BRESP,
    input  logic                        BVALID,
    output logic                        BREADY
);

    axi_state_e                 state_q, state_d;
    logic [`AXI_LEN_BITS-1:0]   cnt_q, cnt_d;
    logic [`AXI_ADDR_BITS-1:0]  addr_q, addr_d;
    logic [`AXI_LEN_BITS-1:0]   len_q, len_d;
    logic                       err_q, err_d;
    logic                       done_q, done_d;
    logic                       w_last;

    // Response IDs are consumed without checking.
    logic unused_ids;
    assign unused_ids = ^{RID, BID};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign w_last = (cnt_q == len_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                addr_d  = req_addr;
                len_d   = req_len;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = req_write ? ST_AW : ST_AR;
            end
            ST_AR: if (ARREADY) state_d = ST_R;
            ST_R: if (RVALID && rd_ready) begin
                // Beat count is informational; RLAST alone ends the burst.
                cnt_d = cnt_q + 1'b1;
                if (RRESP != AXI_RESP_OKAY) err_d = 1'b1;
                if (RLAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_AW: if (AWREADY) state_d = ST_W;
            ST_W: if (wd_valid && WREADY) begin
                if (w_last) begin
                    cnt_d   = '0;
                    state_d = ST_B;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_B: if (BVALID) begin
                err_d   = (BRESP != AXI_RESP_OKAY);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = AXI_SIZE_4B;
    assign ARBURST = AXI_BURST_INCR;
    assign ARVALID = (state_q == ST_AR);

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = AXI_SIZE_4B;
    assign AWBURST = AXI_BURST_INCR;
    assign AWVALID = (state_q == ST_AW);

    // R and W channels are gated pass-throughs of the client streams.
    assign RREADY   = (state_q == ST_R) && rd_ready;
    assign rd_valid = (state_q == ST_R) && RVALID;
    assign rd_last  = (state_q == ST_R) && RLAST;
    assign rd_data  = RDATA;

    assign WVALID   = (state_q == ST_W) && wd_valid;
    assign wd_ready = (state_q == ST_W) && WREADY;
    assign WLAST    = (state_q == ST_W) && w_last;
    assign WDATA    = wd_data;
    assign WSTRB    = wd_strb;

    assign BREADY = (state_q == ST_B);

    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mem_axi_master.sv
// Directed self-checking bench for mem_axi_master; the bench plays both the
// client and the AXI slave. Inputs change 1ns after the rising edge, outputs
// are sampled 2ns after the rising edge.
module tb_mem_axi_master;

    logic                        ACLK = 1'b0;
    logic                        ARESETn;
    logic                        req_valid, req_ready, req_write;
    logic [`AXI_ADDR_BITS-1:0]   req_addr;
    logic [`AXI_LEN_BITS-1:0]    req_len;
    logic                        wd_valid, wd_ready;
    logic [`AXI_DATA_BITS-1:0]   wd_data;
    logic [`AXI_STRB_BITS-1:0]   wd_strb;
    logic                        rd_valid, rd_ready, rd_last;
    logic [`AXI_DATA_BITS-1:0]   rd_data;
    logic                        done, err;
    logic [`AXI_ID_BITS-1:0]     ARID, AWID, RID, BID;
    logic [`AXI_ADDR_BITS-1:0]   ARADDR, AWADDR;
    logic [`AXI_LEN_BITS-1:0]    ARLEN, AWLEN;
    logic [`AXI_SIZE_BITS-1:0]   ARSIZE, AWSIZE;
    logic [`AXI_BURST_BITS-1:0]  ARBURST, AWBURST;
    logic                        ARVALID, ARREADY, AWVALID, AWREADY;
    logic [`AXI_DATA_BITS-1:0]   RDATA, WDATA;
    logic [`AXI_RESP_BITS-1:0]   RRESP, BRESP;
    logic                        RLAST, RVALID, RREADY;
    logic [`AXI_STRB_BITS-1:0]   WSTRB;
    logic                        WLAST, WVALID, WREADY;
    logic                        BVALID, BREADY;

    int tests = 0;
    int fails = 0;

    always #5 ACLK = ~ACLK;

    mem_axi_master #(.MASTER_ID(4'h0)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] len);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
        #1;
        chk("req_ready_idle", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    // Single read beat presented with rd_ready high; checks pass-through.
    task automatic rbeat(input string tag, input logic [31:0] d, input logic last,
                         input logic [1:0] resp);
        RVALID = 1'b1; RDATA = d; RLAST = last; RRESP = resp; rd_ready = 1'b1;
        #1;
        chk({tag, "_rd_valid"}, rd_valid, 1'b1);
        chk({tag, "_rd_data"}, rd_data, d);
        chk({tag, "_rd_last"}, rd_last, last);
        chk({tag, "_rready"}, RREADY, 1'b1);
        tick();
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    endtask

    initial begin
        int k, cyc;
        ARESETn = 1'b0;
        req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
        wd_valid = 0; wd_data = '0; wd_strb = '0; rd_ready = 0;
        ARREADY = 0; AWREADY = 0; WREADY = 0;
        RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
        BID = '0; BRESP = '0; BVALID = 0;
        tick(); tick();
        #1;
        chk("rst_arvalid", ARVALID, 1'b0);
        chk("rst_awvalid", AWVALID, 1'b0);
        chk("rst_bready", BREADY, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        ARESETn = 1'b1;
        tick();

        // ---- read len=3 @0x1000, ARREADY after 2 cycles ----
        issue(1'b0, 32'h0000_1000, 4'd3);
        #1;
        chk("r30_arvalid", ARVALID, 1'b1);
        chk("r30_araddr", ARADDR, 32'h0000_1000);
        chk("r30_arlen", ARLEN, 4'd3);
        chk("r30_arburst", ARBURST, 2'b01);
        chk("r30_arsize", ARSIZE, 3'b010);
        chk("r30_arid", ARID, 4'h0);
        chk("r30_req_ready_busy", req_ready, 1'b0);
        tick(); tick();
        #1;
        chk("r30_arvalid_held", ARVALID, 1'b1);
        chk("r30_araddr_held", ARADDR, 32'h0000_1000);
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        #1;
        chk("r30_arvalid_off", ARVALID, 1'b0);
        for (int i = 0; i < 4; i++)
            rbeat($sformatf("r30_b%0d", i), 32'hA0 + i, (i == 3), 2'b00);
        #1;
        chk("r30_done", done, 1'b1);
        chk("r30_err", err, 1'b0);
        chk("r30_rd_valid_idle", rd_valid, 1'b0);
        tick();
        #1;
        chk("r30_done_pulse", done, 1'b0);

        // ---- write len=0 @0x40 ----
        wd_valid = 1'b1; wd_data = 32'hDEAD_BEEF; wd_strb = 4'b0011; WREADY = 1'b1;
        issue(1'b1, 32'h0000_0040, 4'd0);
        #1;
        chk("w31_awvalid", AWVALID, 1'b1);
        chk("w31_awaddr", AWADDR, 32'h0000_0040);
        chk("w31_awlen", AWLEN, 4'd0);
        chk("w31_awburst", AWBURST, 2'b01);
        chk("w31_no_w_before_aw", WVALID, 1'b0);
        chk("w31_wd_ready_aw", wd_ready, 1'b0);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        #1;
        chk("w31_wvalid", WVALID, 1'b1);
        chk("w31_wlast", WLAST, 1'b1);
        chk("w31_wstrb", WSTRB, 4'b0011);
        chk("w31_wdata", WDATA, 32'hDEAD_BEEF);
        chk("w31_wd_ready", wd_ready, 1'b1);
        tick();
        wd_valid = 1'b0; WREADY = 1'b0;
        #1;
        chk("w31_bready", BREADY, 1'b1);
        chk("w31_wvalid_b", WVALID, 1'b0);
        BVALID = 1'b1; BRESP = 2'b00;
        tick();
        BVALID = 1'b0;
        #1;
        chk("w31_done", done, 1'b1);
        chk("w31_err", err, 1'b0);

        // ---- write len=15, wd_valid every other cycle, WREADY stalls ----
        issue(1'b1, 32'h0000_2000, 4'd15);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 16 && cyc < 200) begin
            wd_valid = (cyc % 2 == 0);
            WREADY   = (cyc % 3 != 1);
            wd_data  = 32'h5000 + k;
            wd_strb  = 4'hF;
            #1;
            if (WVALID && WREADY) begin
                chk($sformatf("w32_data%0d", k), WDATA, 32'h5000 + k);
                chk($sformatf("w32_last%0d", k), WLAST, (k == 15));
                k++;
            end else begin
                chk($sformatf("w32_idle_last_c%0d", cyc), WLAST, (k == 15));
            end
            tick();
            cyc++;
        end
        wd_valid = 1'b0; WREADY = 1'b1;
        chk("w32_beats", k, 16);
        #1;
        chk("w32_no_17th", WVALID, 1'b0);
        chk("w32_bready", BREADY, 1'b1);
        BVALID = 1'b1;
        tick();
        BVALID = 1'b0; WREADY = 1'b0;
        #1;
        chk("w32_done", done, 1'b1);

        // ---- read len=1, SLVERR on 2nd beat, rd_ready low 3 cycles ----
        issue(1'b0, 32'h0000_3000, 4'd1);
        #1;
        chk("r33_arlen", ARLEN, 4'd1);
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        rbeat("r33_b0", 32'h11, 1'b0, 2'b00);
        RVALID = 1'b1; RDATA = 32'h22; RLAST = 1'b1; RRESP = 2'b10; rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("r33_rready_lo%0d", i), RREADY, 1'b0);
            chk($sformatf("r33_rd_valid_stall%0d", i), rd_valid, 1'b1);
            tick();
        end
        rd_ready = 1'b1;
        #1;
        chk("r33_rready_hi", RREADY, 1'b1);
        tick();
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        #1;
        chk("r33_done", done, 1'b1);
        chk("r33_err", err, 1'b1);

        // ---- reset during W beat 2 of len=3 write ----
        issue(1'b1, 32'h0000_4000, 4'd3);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        wd_valid = 1'b1; WREADY = 1'b1; wd_data = 32'h70;
        tick();
        wd_data = 32'h71;
        tick();
        wd_data = 32'h72; WREADY = 1'b0;
        #1;
        chk("r34_wvalid_pre", WVALID, 1'b1);
        chk("r34_wlast_pre", WLAST, 1'b0);
        ARESETn = 1'b0;
        #1;
        chk("r34_wvalid_rst", WVALID, 1'b0);
        chk("r34_awvalid_rst", AWVALID, 1'b0);
        chk("r34_bready_rst", BREADY, 1'b0);
        chk("r34_wd_ready_rst", wd_ready, 1'b0);
        wd_valid = 1'b0;
        tick();
        ARESETn = 1'b1;
        #1;
        chk("r34_req_ready_rel", req_ready, 1'b1);
        chk("r34_no_done", done, 1'b0);
        issue(1'b0, 32'h0000_5000, 4'd0);
        #1;
        chk("r34_new_arvalid", ARVALID, 1'b1);
        chk("r34_new_araddr", ARADDR, 32'h0000_5000);
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        rbeat("r34_rd", 32'hBB, 1'b1, 2'b00);
        #1;
        chk("r34_done", done, 1'b1);

        // ---- req_valid held during B wait ----
        wd_valid = 1'b1; WREADY = 1'b1; wd_data = 32'h99; wd_strb = 4'hF;
        issue(1'b1, 32'h0000_6000, 4'd0);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        tick();
        wd_valid = 1'b0; WREADY = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_7000; req_len = 4'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("r35_req_ready_b%0d", i), req_ready, 1'b0);
            chk($sformatf("r35_bready%0d", i), BREADY, 1'b1);
            tick();
        end
        BVALID = 1'b1; BRESP = 2'b10;
        #1;
        chk("r35_req_ready_hs", req_ready, 1'b0);
        tick();
        BVALID = 1'b0; BRESP = 2'b00;
        #1;
        chk("r35_req_ready_after", req_ready, 1'b1);
        chk("r35_done", done, 1'b1);
        chk("r35_err", err, 1'b1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("r35_next_arvalid", ARVALID, 1'b1);
        chk("r35_next_araddr", ARADDR, 32'h0000_7000);
        chk("r35_err_cleared", err, 1'b0);
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        rbeat("r35_rd", 32'hCC, 1'b1, 2'b00);
        #1;
        chk("r35_rd_done", done, 1'b1);
        chk("r35_rd_err", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_axi_master.md
MEM_AXI_MASTER -- requirements
Module: mem_axi_master

Interface
REQ-001 Parameter MASTER_ID, default 0, constant ARID/AWID value, width `AXI_ID_BITS.
REQ-002 ACLK  in  1  single clock; all state updates on rising edge.
REQ-003 ARESETn  in  1  reset; asynchronous, active-low.
REQ-004 req_valid/req_ready  in/out  1/1  request handshake from client.
REQ-005 req_write  in  1  1 = write burst, 0 = read burst.
REQ-006 req_addr  in  `AXI_ADDR_BITS  byte address of first beat, word-aligned.
REQ-007 req_len  in  `AXI_LEN_BITS  beats minus one.
REQ-008 wd_valid/wd_ready  in/out  1/1, wd_data  in  `AXI_DATA_BITS, wd_strb  in  `AXI_STRB_BITS  write-data stream.
REQ-009 rd_valid/rd_ready  out/in  1/1, rd_data  out  `AXI_DATA_BITS, rd_last  out  1  read-data stream.
REQ-010 done  out  1  one-cycle completion pulse; err  out  1  valid with done, 1 = any non-OKAY response.
REQ-011 AXI master ports: full AR, R, AW, W, B channels (ARID..ARVALID/ARREADY, RID..RREADY, AWID..AWREADY, WDATA/WSTRB/WLAST/WVALID/WREADY, BID/BRESP/BVALID/BREADY), widths from `AXI_*_BITS macros.

Function
REQ-012 FSM states IDLE, AR, R, AW, W, B; one transaction outstanding at a time.
REQ-013 req_ready = 1 only in IDLE; on req_valid&req_ready, addr/len/write are registered and state goes AR (read) or AW (write).
REQ-014 AR: ARVALID=1 with registered ARADDR/ARLEN, ARID=MASTER_ID, ARSIZE=3'b010, ARBURST=2'b01 (INCR); held stable until ARREADY; on handshake -> R.
REQ-015 R: RREADY=rd_ready, rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST, all combinational pass-through; each R handshake increments beat counter.
REQ-016 R exit: on R handshake with RLAST=1 -> IDLE, done=1 next cycle; counter reaching len without RLAST is ignored (RLAST governs).
REQ-017 AW: AWVALID=1, same field rules as REQ-014; held until AWREADY; on handshake -> W. No W beat is offered before AW handshake.
REQ-018 W: WVALID=wd_valid, wd_ready=WREADY, WDATA/WSTRB pass-through; WLAST=1 when beat counter == registered len.
REQ-019 W exit: on W handshake with WLAST=1 -> B, counter cleared.
REQ-020 B: BREADY=1; on BVALID -> IDLE, done=1 next cycle, err=(BRESP!=OKAY).
REQ-021 Read err = OR of (RRESP!=OKAY) over all beats of burst, accumulated in sticky flag cleared on request acceptance.
REQ-022 Outside their state, ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY, wd_ready, rd_valid = 0.
REQ-023 Beat counter `AXI_LEN_BITS wide; len=0 gives single beat with WLAST/RLAST on first beat; len=15 gives 16 beats, no wrap.
REQ-024 req_valid while busy: held off by req_ready=0, no queuing.
REQ-025 Mismatched RID/BID are not checked; responses consumed as-is.

Reset
REQ-026 ARESETn low: state IDLE, counter 0, registered addr/len 0, err flag 0, done 0; all AXI VALID/READY outputs and wd_ready/rd_valid 0 immediately (asynchronous).
REQ-027 Reset mid-burst abandons transaction; no done pulse; req_ready=1 first cycle after release.

Structure
REQ-028 State enum and burst/size constants (INCR, size 4 bytes) in shared AXI package alongside AXI_define macros.
REQ-029 Single module, no sub-module; FSM and beat counter inline.

Verification
REQ-030 Read len=3 addr 0x0000_1000, slave returns 0xA0..0xA3, ARREADY after 2 cycles -> ARLEN=3, ARBURST=01, four rd beats, rd_last on 0xA3, done=1, err=0.
REQ-031 Write len=0 addr 0x0000_0040 data 0xDEADBEEF strb 4'b0011 -> one W beat with WLAST=1, WSTRB=0011, BRESP=OKAY -> done=1, err=0.
REQ-032 Write len=15 with wd_valid toggling every other cycle and WREADY stalls -> exactly 16 W beats, WLAST only on 16th, data order preserved.
REQ-033 Read len=1 with second RRESP=SLVERR and rd_ready low 3 cycles mid-burst -> RREADY follows rd_ready, done=1 with err=1.
REQ-034 ARESETn asserted during W beat 2 of len=3 write -> WVALID, AWVALID, BREADY drop same cycle, no done; new read accepted after release.
REQ-035 req_valid held during B wait -> req_ready stays 0 until cycle after B handshake, next request then accepted.
